// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared sizing constants for the 8x8 register file
package rf_pkg;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int NREGS  = 1 << ADDR_W;

    localparam logic [ADDR_W-1:0] ZERO_REG = '0;
endpackage

// File: rtl/load_reg_word.sv
// rtl/load_reg_word.sv - DATA_W-bit load-enabled register with async active-low clear
module load_reg_word
    import rf_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         LOAD,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (LOAD) begin
            q <= d;
        end
    end

endmodule

// File: rtl/register_file_8x8.sv
// rtl/register_file_8x8.sv - 8x8 register file, one write port, two combinational read ports, r0 hardwired to zero
module register_file_8x8
    import rf_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [NREGS-1:0]  load_vec
);

    logic [DATA_W-1:0] regs [NREGS];

    // Bit 0 is never decoded, so a write to r0 produces no strobe at all.
    always_comb begin
        load_vec = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (we && (wa == ADDR_W'(i))) begin
                load_vec[i] = 1'b1;
            end
        end
    end

    assign regs[0] = '0;

    for (genvar i = 1; i < NREGS; i++) begin : g_reg
        load_reg_word #(
            .W(DATA_W)
        ) u_word (
            .clk  (clk),
            .rst_n(rst_n),
            .LOAD (load_vec[i]),
            .d    (wd),
            .q    (regs[i])
        );
    end

    // No write bypass: a same-cycle read sees the value from before the edge.
    assign rd1 = (ra1 == ZERO_REG) ? '0 : regs[ra1];
    assign rd2 = (ra2 == ZERO_REG) ? '0 : regs[ra2];

endmodule

// File: tb/tb_register_file_8x8.sv
// tb/tb_register_file_8x8.sv - directed vector bench for register_file_8x8
module tb_register_file_8x8;
    import rf_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [NREGS-1:0]  load_vec;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        logic [ADDR_W-1:0] ra1;
        logic [ADDR_W-1:0] ra2;
        logic [DATA_W-1:0] exp_rd1;
        logic [DATA_W-1:0] exp_rd2;
        logic [NREGS-1:0]  exp_load;
    } vec_t;

    vec_t vecs [14];

    register_file_8x8 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we),
        .wa      (wa),
        .wd      (wd),
        .ra1     (ra1),
        .ra2     (ra2),
        .rd1     (rd1),
        .rd2     (rd2),
        .load_vec(load_vec)
    );

    always #50 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic sweep_zero(input string tag);
        for (int i = 0; i < NREGS; i++) begin
            ra1 = ADDR_W'(i);
            ra2 = ADDR_W'(NREGS - 1 - i);
            #1;
            check($sformatf("%s_rd1_r%0d", tag, i), rd1, 8'h00);
            check($sformatf("%s_rd2_r%0d", tag, NREGS - 1 - i), rd2, 8'h00);
        end
    endtask

    initial begin
        // Expected rd values are those seen just before each row's clock edge.
        //          we    wa    wd     ra1   ra2   rd1    rd2    load
        vecs[0]  = '{1'b1, 3'd3, 8'h5A, 3'd3, 3'd0, 8'h00, 8'h00, 8'h08};
        vecs[1]  = '{1'b1, 3'd7, 8'hC3, 3'd3, 3'd7, 8'h5A, 8'h00, 8'h80};
        vecs[2]  = '{1'b0, 3'd0, 8'h00, 3'd3, 3'd7, 8'h5A, 8'hC3, 8'h00};
        vecs[3]  = '{1'b0, 3'd0, 8'h00, 3'd1, 3'd2, 8'h00, 8'h00, 8'h00};
        vecs[4]  = '{1'b1, 3'd0, 8'hFF, 3'd0, 3'd3, 8'h00, 8'h5A, 8'h00};
        vecs[5]  = '{1'b0, 3'd0, 8'h00, 3'd0, 3'd7, 8'h00, 8'hC3, 8'h00};
        vecs[6]  = '{1'b1, 3'd5, 8'h11, 3'd5, 3'd5, 8'h00, 8'h00, 8'h20};
        vecs[7]  = '{1'b1, 3'd5, 8'h22, 3'd5, 3'd5, 8'h11, 8'h11, 8'h20};
        vecs[8]  = '{1'b0, 3'd5, 8'h22, 3'd5, 3'd5, 8'h22, 8'h22, 8'h00};
        vecs[9]  = '{1'b1, 3'd2, 8'h3C, 3'd2, 3'd2, 8'h00, 8'h00, 8'h04};
        vecs[10] = '{1'b0, 3'd2, 8'h00, 3'd2, 3'd3, 8'h3C, 8'h5A, 8'h00};
        vecs[11] = '{1'b0, 3'd2, 8'h00, 3'd2, 3'd3, 8'h3C, 8'h5A, 8'h00};
        vecs[12] = '{1'b0, 'x,   'x,    3'd2, 3'd1, 8'h3C, 8'h00, 8'h00};
        vecs[13] = '{1'b0, 3'd2, 8'h00, 3'd2, 3'd7, 8'h3C, 8'hC3, 8'h00};

        rst_n = 1'b0;
        we    = 1'b1;
        wa    = 3'd3;
        wd    = 8'hAA;
        ra1   = 3'd3;
        ra2   = 3'd7;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_load_vec", load_vec, 8'b0000_1000);
        sweep_zero("reset_held");
        we    = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        sweep_zero("after_release");

        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            we  = vecs[k].we;
            wa  = vecs[k].wa;
            wd  = vecs[k].wd;
            ra1 = vecs[k].ra1;
            ra2 = vecs[k].ra2;
            #1;
            check($sformatf("vec%0d_rd1", k), rd1, vecs[k].exp_rd1);
            check($sformatf("vec%0d_rd2", k), rd2, vecs[k].exp_rd2);
            check($sformatf("vec%0d_load_vec", k), load_vec, vecs[k].exp_load);
        end

        for (int i = 1; i < NREGS; i++) begin
            @(negedge clk);
            we = 1'b1;
            wa = ADDR_W'(i);
            wd = 8'(i);
        end
        @(negedge clk);
        we = 1'b0;
        for (int i = 1; i < NREGS; i++) begin
            ra1 = ADDR_W'(i);
            #1;
            check($sformatf("fill_r%0d", i), rd1, 8'(i));
        end

        // Reset falls between edges and is held across the edge carrying a write to r4.
        we = 1'b1;
        wa = 3'd4;
        wd = 8'h99;
        #2;
        rst_n = 1'b0;
        #1;
        sweep_zero("async_reset");
        @(posedge clk);
        @(negedge clk);
        we    = 1'b0;
        rst_n = 1'b1;
        #1;
        sweep_zero("post_async");

        @(negedge clk);
        we  = 1'b1;
        wa  = 3'd4;
        wd  = 8'h44;
        ra1 = 3'd4;
        ra2 = 3'd6;
        @(negedge clk);
        we = 1'b0;
        #1;
        check("rewrite_r4", rd1, 8'h44);
        check("rewrite_r6_untouched", rd2, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/register_file_8x8.md
# register_file_8x8

Architectural register file for the single-cycle RISC datapath, built from load-enabled D flip-flop storage. It sits between writeback and decode/operand fetch. Each cycle it accepts one write (address, data, enable) and turns it into one-hot per-register LOAD strobes. It serves two independent combinational read ports to the ALU operand muxes. Register 0 always reads zero.

## Interface
- DATA_W, 8, width of each register and of the data ports
- ADDR_W, 3, register address width; NREGS = 2**ADDR_W = 8
- clk  in  1  single rising-edge clock for all storage
- rst_n  in  1  reset; asynchronous, active-low; clears all registers
- we  in  1  write enable for this cycle
- wa  in  ADDR_W  write address
- wd  in  DATA_W  write data
- ra1  in  ADDR_W  read address, port 1
- ra2  in  ADDR_W  read address, port 2
- rd1  out  DATA_W  read data, port 1
- rd2  out  DATA_W  read data, port 2
- load_vec  out  NREGS  per-register LOAD strobes (debug/verification visibility)

## Operation
- Storage: registers r1..r7, each DATA_W bits. r0 has no storage and reads constant 0.
- Write decode: load_vec[i] = we && (wa == i) for i ≥ 1. load_vec[0] is always 0.
  - At most one bit of load_vec is high at any time.
- Write: on a rising clk edge with load_vec[i] = 1, register ri takes wd. All other registers hold.
- Write to r0 (we=1, wa=0): no effect. No register changes. load_vec stays all-zero.
- we=0: wa and wd are ignored. All registers hold regardless of X/Z on wa or wd.
- Read: rd1 = (ra1 == 0) ? 0 : r[ra1], and likewise for rd2. Both are purely combinational from stored state.
- Both ports may address the same register; both then return the same value.
- Read-during-write to the same address in the same cycle returns the OLD value. There is no bypass; the new value is visible after the edge.
- Reset: rst_n low clears r1..r7 to 0 immediately, without waiting for clk. Consequently rd1 = rd2 = 0 for every address while reset is held.
- Release of reset: the first write can take effect on the first rising clk edge at which rst_n is already high.
- Reset asserted mid-operation overrides any write pending at the same edge. The register ends at 0.

## Timing
- Write latency: 1 clk edge. Data written at edge N is readable on rd1/rd2 combinationally after edge N.
- Read latency: 0 cycles (combinational path from ra* through the read mux).
- load_vec is combinational from we and wa. It must be stable before the rising edge; it is not registered.
- Reset values: r1..r7 = 0, rd1 = 0, rd2 = 0. load_vec follows we/wa and is 0 when we = 0.
- There is one write per cycle. There are no handshakes and no stall input; the datapath controls we.

## Structure
- Shared package rf_pkg:
  - DATA_W, ADDR_W and NREGS constants
  - the ZERO_REG = 0 address constant
- Sub-module load_reg_word: a DATA_W-bit register with async active-low clear and LOAD enable.
  - It is instantiated for i = 1..NREGS-1 via generate.
  - Its .LOAD input is connected to load_vec[i].
- Top level contains:
  - the write decoder
  - the generate loop
  - two NREGS:1 read muxes with the r0 zero override

## Test plan
- Reset: hold rst_n=0 with we=1, wa=3, wd=8'hAA across two clk edges → all reads return 0x00 and load_vec==8'b0000_1000. After release, no register is nonzero.
- Basic write/read: write 0x5A to r3, then 0xC3 to r7 → next cycle, ra1=3 gives rd1=0x5A and ra2=7 gives rd2=0xC3. Other registers read 0x00.
- r0 protection: we=1, wa=0, wd=0xFF → load_vec==0. After the edge, rd1 (ra1=0) is 0x00 and r1..r7 are unchanged.
- Read-during-write: r5=0x11, then in the same cycle write 0x22 to r5 with ra1=ra2=5 → rd1=rd2=0x11 before the edge and 0x22 after it.
- we=0 hold: r2=0x3C, then we=0, wa=2, wd=0x00 for 3 edges → rd of r2 stays 0x3C. load_vec==0 throughout.
- Async reset mid-run: r1..r7 loaded with 0x01..0x07. Pulse rst_n low between clk edges → all reads drop to 0x00 before the next edge. The write coinciding with the reset edge is lost.
